io_port_ctrl: RTL and testbench

Memory-mapped I/O responder on the CPU side of the in_port/out_port interface of sc_computer. It accepts CPU stores to three output registers and answers CPU loads from two synchronized input ports plus a change-status register. It also drives six active-low seven-segment digits, showing each out_port value in decimal through a shared sequential binary-to-BCD converter.

---
 rtl/io_port_ctrl_if.sv | 18 +
 rtl/io_port_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_io_port_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - CPU load/store bus between sc_computer and the I/O port responder
interface io_port_ctrl_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic        read_io_enable;
    logic [31:0] io_read_data;

    modport master (
        output addr, datain, write_io_enable, read_io_enable,
        input  io_read_data
    );

    modport slave (
        input  addr, datain, write_io_enable, read_io_enable,
        output io_read_data
    );
endinterface

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped I/O responder with synchronized inputs and 7-segment decimal display
module io_port_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_DISP    = 99
) (
    input  logic          clock,
    input  logic          resetn,
    io_port_ctrl_if.slave bus,
    input  logic [31:0]   in_port0,
    input  logic [31:0]   in_port1,
    output logic [31:0]   out_port0,
    output logic [31:0]   out_port1,
    output logic [31:0]   out_port2,
    output logic [6:0]    hex5,
    output logic [6:0]    hex4,
    output logic [6:0]    hex3,
    output logic [6:0]    hex2,
    output logic [6:0]    hex1,
    output logic [6:0]    hex0
);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    logic [31:0] r_out   [3];
    logic [13:0] r_hex   [3];
    logic [31:0] r_sync0 [SYNC_STAGES];
    logic [31:0] r_sync1 [SYNC_STAGES];
    logic [1:0]  r_status;
    logic [2:0]  r_dirty;
    state_t      r_state,  w_state_nxt;
    logic [14:0] r_sr,     w_sr_nxt;
    logic [2:0]  r_cnt,    w_cnt_nxt;
    logic [1:0]  r_port,   w_port_nxt;
    logic        r_ovf,    w_ovf_nxt;
    logic [2:0]  w_dirty_clr;
    logic        w_disp_we;
    logic [1:0]  w_sel;
    logic [31:0] w_sel_val;

    logic [5:0]  w_idx;
    logic [2:0]  w_store_hit;
    logic [1:0]  w_chg;
    logic        w_clr;
    logic        w_unused;

    assign w_idx    = bus.addr[7:2];
    assign w_unused = ^{bus.addr[31:8], bus.addr[1:0]};

    assign w_store_hit[0] = bus.write_io_enable && (w_idx == 6'h20);
    assign w_store_hit[1] = bus.write_io_enable && (w_idx == 6'h21);
    assign w_store_hit[2] = bus.write_io_enable && (w_idx == 6'h22);
    assign w_clr          = bus.read_io_enable  && (w_idx == 6'h32);

    // A change is seen while the new value sits between the last two sync stages
    assign w_chg[0] = r_sync0[SYNC_STAGES-1] != r_sync0[SYNC_STAGES-2];
    assign w_chg[1] = r_sync1[SYNC_STAGES-1] != r_sync1[SYNC_STAGES-2];

    assign out_port0 = r_out[0];
    assign out_port1 = r_out[1];
    assign out_port2 = r_out[2];
    assign {hex5, hex4} = r_hex[0];
    assign {hex3, hex2} = r_hex[1];
    assign {hex1, hex0} = r_hex[2];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    endfunction

    // Shift-add-3: ones nibble at [10:7], tens at [14:11], binary below
    function automatic logic [14:0] bcd_step(input logic [14:0] sr);
        logic [14:0] t;
        t = sr;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        bcd_step = {t[13:0], 1'b0};
    endfunction

    always_comb begin
        bus.io_read_data = 32'd0;
        case (w_idx)
            6'h20:   bus.io_read_data = r_out[0];
            6'h21:   bus.io_read_data = r_out[1];
            6'h22:   bus.io_read_data = r_out[2];
            6'h30:   bus.io_read_data = r_sync0[SYNC_STAGES-1];
            6'h31:   bus.io_read_data = r_sync1[SYNC_STAGES-1];
            6'h32:   bus.io_read_data = {30'd0, r_status};
            default: bus.io_read_data = 32'd0;
        endcase
    end

    always_comb begin
        w_sel = r_dirty[0] ? 2'd0 : (r_dirty[1] ? 2'd1 : 2'd2);
        w_sel_val = r_out[w_sel];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_port_nxt  = r_port;
        w_ovf_nxt   = r_ovf;
        w_dirty_clr = 3'b000;
        w_disp_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dirty != 3'b000) begin
                    w_port_nxt         = w_sel;
                    w_dirty_clr[w_sel] = 1'b1;
                    w_ovf_nxt          = w_sel_val > 32'(MAX_DISP);
                    w_sr_nxt           = {8'd0, w_sel_val[6:0]};
                    w_cnt_nxt          = 3'd7;
                    w_state_nxt        = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sr_nxt  = bcd_step(r_sr);
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_disp_we   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_port   <= '0;
            r_ovf    <= 1'b0;
            r_dirty  <= '0;
            r_status <= '0;
            for (int i = 0; i < 3; i++) begin
                r_out[i] <= '0;
                r_hex[i] <= {SEG_ZERO, SEG_ZERO};
            end
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync0[i] <= '0;
                r_sync1[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_port  <= w_port_nxt;
            r_ovf   <= w_ovf_nxt;
            // New stores dominate the clear issued when a port is picked up
            r_dirty  <= (r_dirty & ~w_dirty_clr) | w_store_hit;
            r_status <= (r_status & ~{2{w_clr}}) | w_chg;
            for (int i = 0; i < 3; i++)
                if (w_store_hit[i]) r_out[i] <= bus.datain;
            if (w_disp_we)
                r_hex[r_port] <= r_ovf ? {SEG_DASH, SEG_DASH}
                                       : {seg(r_sr[14:11]), seg(r_sr[10:7])};
            r_sync0[0] <= in_port0;
            r_sync1[0] <= in_port1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync0[i] <= r_sync0[i-1];
                r_sync1[i] <= r_sync1[i-1];
            end
        end
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - scoreboard bench for io_port_ctrl
module tb_io_port_ctrl;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] in_port0 = 32'd0;
    logic [31:0] in_port1 = 32'd0;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;

    typedef struct {
        int          port;
        logic [13:0] disp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    io_port_ctrl_if bus ();

    io_port_ctrl #(.SYNC_STAGES(2), .MAX_DISP(99)) dut (
        .clock(clock), .resetn(resetn), .bus(bus),
        .in_port0(in_port0), .in_port1(in_port1),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_model(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [13:0] exp_disp(input int v);
        if (v > 99) return {7'b0111111, 7'b0111111};
        return {seg_model(v / 10), seg_model(v % 10)};
    endfunction

    function automatic logic [13:0] port_disp(input int p);
        if (p == 0) return {hex5, hex4};
        if (p == 1) return {hex3, hex2};
        return {hex1, hex0};
    endfunction

    task automatic store(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.addr = {24'd0, a};
        bus.datain = d;
        bus.write_io_enable = 1'b1;
        @(posedge clock);
        #1 bus.write_io_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic clr, output logic [31:0] d);
        @(negedge clock);
        bus.addr = {24'd0, a};
        bus.read_io_enable = clr;
        #1 d = bus.io_read_data;
        @(posedge clock);
        #1 bus.read_io_enable = 1'b0;
    endtask

    // Waits for the next display change; port = -1 on timeout
    task automatic wait_disp(output int port, output int lat);
        logic [41:0] prev, cur;
        prev = {hex5, hex4, hex3, hex2, hex1, hex0};
        port = -1;
        lat  = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1 cur = {hex5, hex4, hex3, hex2, hex1, hex0};
            if (cur !== prev) begin
                lat = n;
                if (cur[41:28] !== prev[41:28])      port = 0;
                else if (cur[27:14] !== prev[27:14]) port = 1;
                else                                 port = 2;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.addr = 32'd0;
        bus.datain = 32'd0;
        bus.write_io_enable = 1'b0;
        bus.read_io_enable = 1'b0;
        in_port0 = 32'd5;
        in_port1 = 32'd10;
        repeat (3) @(posedge clock);
        #1;
        for (int p = 0; p < 3; p++) begin
            n_vec++;
            if (port_disp(p) !== {7'b1000000, 7'b1000000}) begin
                n_err++;
                $display("FAIL reset_hex port%0d got=%b want=%b", p, port_disp(p), {7'b1000000, 7'b1000000});
            end
        end
        n_vec++;
        if ({out_port0, out_port1, out_port2} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_out got=%h want=0", {out_port0, out_port1, out_port2});
        end
        @(negedge clock) resetn = 1'b1;
        repeat (2) @(posedge clock);
        rd(8'hC0, 1'b0, d);
        n_vec++;
        if (d !== 32'd5) begin n_err++; $display("FAIL rd_in0 got=%0d want=5", d); end
        rd(8'hC4, 1'b0, d);
        n_vec++;
        if (d !== 32'd10) begin n_err++; $display("FAIL rd_in1 got=%0d want=10", d); end
        rd(8'hC8, 1'b1, d);
        n_vec++;
        if (d !== 32'd3) begin n_err++; $display("FAIL rd_status got=%0d want=3", d); end
        rd(8'hC8, 1'b0, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL status_cleared got=%0d want=0", d); end
        rd(8'h90, 1'b0, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL rd_unmapped got=%h want=0", d); end
    endtask

    task automatic test_single();
        int p, lat;
        exp_t e;
        sb.push_back('{0, exp_disp(15)});
        store(8'h80, 32'd15);
        n_vec++;
        if (out_port0 !== 32'd15) begin n_err++; $display("FAIL store_out0 got=%0d want=15", out_port0); end
        wait_disp(p, lat);
        e = sb.pop_front();
        n_vec++;
        if (p !== e.port || port_disp(e.port) !== e.disp) begin
            n_err++;
            $display("FAIL single_disp port got=%0d want=%0d disp got=%b want=%b", p, e.port, port_disp(e.port), e.disp);
        end
        n_vec++;
        if (lat !== 9) begin n_err++; $display("FAIL single_latency got=%0d want=9", lat); end
    endtask

    task automatic test_back_to_back();
        int p, lat;
        exp_t e;
        logic [31:0] d;
        sb.push_back('{0, exp_disp(99)});
        sb.push_back('{1, exp_disp(7)});
        sb.push_back('{2, exp_disp(150)});
        store(8'h80, 32'd99);
        store(8'h84, 32'd7);
        store(8'h88, 32'd150);
        store(8'hC0, 32'd1234);
        rd(8'h88, 1'b0, d);
        n_vec++;
        if (d !== 32'd150) begin n_err++; $display("FAIL rd_out2 got=%0d want=150", d); end
        rd(8'hC0, 1'b0, d);
        n_vec++;
        if (d !== 32'd5) begin n_err++; $display("FAIL ro_store_ignored got=%0d want=5", d); end
        for (int k = 0; k < 3; k++) begin
            wait_disp(p, lat);
            e = sb.pop_front();
            n_vec++;
            if (p !== e.port || port_disp(e.port) !== e.disp) begin
                n_err++;
                $display("FAIL b2b_disp%0d port got=%0d want=%0d disp got=%b want=%b", k, p, e.port, port_disp(e.port), e.disp);
            end
        end
    endtask

    task automatic test_reconvert();
        int p, lat;
        exp_t e;
        sb.push_back('{1, exp_disp(42)});
        store(8'h84, 32'd42);
        repeat (3) @(posedge clock);
        sb.push_back('{1, exp_disp(8)});
        store(8'h84, 32'd8);
        for (int k = 0; k < 2; k++) begin
            wait_disp(p, lat);
            e = sb.pop_front();
            n_vec++;
            if (p !== e.port || port_disp(e.port) !== e.disp) begin
                n_err++;
                $display("FAIL reconv_disp%0d port got=%0d want=%0d disp got=%b want=%b", k, p, e.port, port_disp(e.port), e.disp);
            end
        end
    endtask

    task automatic test_status();
        logic [31:0] d;
        rd(8'hC8, 1'b1, d);
        @(negedge clock);
        in_port1 = in_port1 ^ 32'd1;
        bus.addr = 32'hC8;
        bus.read_io_enable = 1'b1;
        @(negedge clock);
        in_port1 = in_port1 ^ 32'd1;
        repeat (2) @(posedge clock);
        #1 bus.read_io_enable = 1'b0;
        rd(8'hC8, 1'b0, d);
        n_vec++;
        if (d !== 32'd2) begin n_err++; $display("FAIL set_beats_clear got=%0d want=2", d); end
        rd(8'hC8, 1'b1, d);
        rd(8'hC8, 1'b0, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL status_clear2 got=%0d want=0", d); end
    endtask

    task automatic test_mid_reset();
        int p, lat;
        exp_t e;
        store(8'h84, 32'd77);
        repeat (4) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({out_port0, out_port1, out_port2} !== 96'd0) begin
            n_err++;
            $display("FAIL async_reset_out got=%h want=0", {out_port0, out_port1, out_port2});
        end
        n_vec++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'b1000000}}) begin
            n_err++;
            $display("FAIL async_reset_hex got=%h want=%h", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'b1000000}});
        end
        @(negedge clock) resetn = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        n_vec++;
        if ({hex3, hex2} !== {7'b1000000, 7'b1000000}) begin
            n_err++;
            $display("FAIL no_stale_conv got=%b want=%b", {hex3, hex2}, {7'b1000000, 7'b1000000});
        end
        sb.push_back('{2, exp_disp(3)});
        store(8'h88, 32'd3);
        wait_disp(p, lat);
        e = sb.pop_front();
        n_vec++;
        if (p !== e.port || port_disp(e.port) !== e.disp || lat !== 9) begin
            n_err++;
            $display("FAIL post_reset_conv port got=%0d want=%0d disp got=%b want=%b lat got=%0d want=9", p, e.port, port_disp(e.port), e.disp, lat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reconvert();
        test_status();
        test_mid_reset();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
